// File: rtl/rd_burst_ctrl.sv
// Purpose : fast-domain read-burst controller; each rising edge of the synchronized
//           read-enable level issues a BURST_LEN-word read burst to a standard (non-FWFT) FIFO.
// Latency : rise sampled at edge N -> first fifo_rd in cycle N+1; DONE follows the last read by one cycle.
// Backpr. : fifo_rd is withheld while fifo_empty is high; after TIMEOUT consecutive empty
//           cycles (TIMEOUT != 0) the burst is aborted and flagged with burst_err.
//
// Ports
//   clk, rstn   : clock and synchronous active-low reset
//   rd_en_i     : synchronized read-enable level (clk domain)
//   fifo_empty  : FIFO empty flag
//   fifo_rd     : FIFO read strobe, one word per high cycle
//   busy        : high while a burst is running or completing (BURST, DONE)
//   burst_done  : one-cycle pulse at the end of every burst, normal or aborted
//   burst_err   : qualifies burst_done; 1 = aborted on stall timeout
//   beat_cnt    : reads done in the current burst; holds until the next burst starts
//   drop_cnt    : rising edges ignored while busy
//
// Build option: define RD_BURST_DROP_CNT_EN to get a saturating drop counter;
// without it drop_cnt is tied to zero.

module rd_burst_ctrl #(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rd_en_i,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic             busy,
    output logic             burst_done,
    output logic             burst_err,
    output logic [7:0]       beat_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    // Stall counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int              ST_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [7:0]      BEAT_LAST  = 8'(BURST_LEN - 1);
    localparam logic [ST_W-1:0] STALL_LAST = ST_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rd_en_q;
    logic            rise;
    logic [ST_W-1:0] stall_cnt;
    logic [ST_W-1:0] stall_nxt;
    logic [7:0]      beat_nxt;
    logic            done_nxt;
    logic            err_nxt;

    // rd_en_q resets low, so a level already high when reset releases counts as a rise.
    assign rise = rd_en_i & ~rd_en_q;
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        stall_nxt = stall_cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        fifo_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_BURST;
                    beat_nxt  = 8'd0;
                    stall_nxt = '0;
                end
            end
            S_BURST: begin
                if (!fifo_empty) begin
                    // Strobe is suppressed during reset so no word is lost from the FIFO.
                    fifo_rd   = rstn;
                    beat_nxt  = beat_cnt + 8'd1;
                    stall_nxt = '0;
                    if (beat_cnt == BEAT_LAST) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    stall_nxt = stall_cnt + 1'b1;
                    // Abort on the TIMEOUT-th consecutive empty cycle.
                    if ((TIMEOUT != 0) && (stall_cnt == STALL_LAST)) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // burst_done/burst_err are registered so they line up exactly with the DONE state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            rd_en_q    <= 1'b0;
            beat_cnt   <= 8'd0;
            stall_cnt  <= '0;
            burst_done <= 1'b0;
            burst_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_en_q    <= rd_en_i;
            beat_cnt   <= beat_nxt;
            stall_cnt  <= stall_nxt;
            burst_done <= done_nxt;
            burst_err  <= err_nxt;
        end
    end

`ifdef RD_BURST_DROP_CNT_EN
    // A rise while not IDLE (including the DONE cycle) is not queued, only counted.
    logic drop;
    assign drop = rise & (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Purpose : directed self-checking bench for rd_burst_ctrl (BURST_LEN=4, TIMEOUT=16, CNT_W=2).
// Latency : inputs change 1 ns after posedge; outputs sampled on negedge.
// Backpr. : fifo_empty is driven directly to create stalls and timeouts.

module tb_rd_burst_ctrl;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rstn;
    logic             rd_en_i;
    logic             fifo_empty;
    logic             fifo_rd;
    logic             busy;
    logic             burst_done;
    logic             burst_err;
    logic [7:0]       beat_cnt;
    logic [CNT_W-1:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-window statistics collected by step()
    int cyc;
    int rd_cnt;
    int done_cnt;
    int done_err;
    int done_beat;
    int first_rd_cyc;
    int done_cyc;

    rd_burst_ctrl #(
        .BURST_LEN (4),
        .TIMEOUT   (16),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rd_en_i    (rd_en_i),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .busy       (busy),
        .burst_done (burst_done),
        .burst_err  (burst_err),
        .beat_cnt   (beat_cnt),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc          = 0;
        rd_cnt       = 0;
        done_cnt     = 0;
        done_err     = -1;
        done_beat    = -1;
        first_rd_cyc = -1;
        done_cyc     = -1;
    endtask

    // Sample the current cycle at negedge, then advance to just after the next posedge.
    task automatic step();
        @(negedge clk);
        if (fifo_rd) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (burst_done) begin
            done_cnt++;
            done_err  = int'(burst_err);
            done_beat = int'(beat_cnt);
            done_cyc  = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drop the level for one cycle, then raise it and open a fresh stats window.
    task automatic new_rise();
        rd_en_i = 1'b0;
        step();
        rd_en_i = 1'b1;
        clear_stats();
    endtask

    int exp_drop2;
    int exp_drop5;

    initial begin
`ifdef RD_BURST_DROP_CNT_EN
        exp_drop2 = 2;
        exp_drop5 = 3;   // five drops saturate a 2-bit counter
`else
        exp_drop2 = 0;
        exp_drop5 = 0;
`endif
        rstn       = 1'b0;
        rd_en_i    = 1'b0;
        fifo_empty = 1'b0;
        clear_stats();
        @(posedge clk);
        #1;
        steps(3);

        // Reset state
        @(negedge clk);
        chk("rst_fifo_rd", int'(fifo_rd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(burst_done), 0);
        chk("rst_err", int'(burst_err), 0);
        chk("rst_beat", int'(beat_cnt), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        @(posedge clk);
        #1;

        // 1. Basic burst
        rstn    = 1'b1;
        rd_en_i = 1'b1;
        clear_stats();
        steps(8);
        chk("t1_reads", rd_cnt, 4);
        chk("t1_first_rd_cyc", first_rd_cyc, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_cyc", done_cyc, 5);
        chk("t1_err", done_err, 0);
        chk("t1_beat_at_done", done_beat, 4);
        @(negedge clk);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_beat_hold", int'(beat_cnt), 4);
        @(posedge clk);
        #1;

        // 2. Stall of 5 cycles after the 2nd read
        new_rise();
        steps(3);
        chk("t2_reads_before_stall", rd_cnt, 2);
        fifo_empty = 1'b1;
        steps(5);
        chk("t2_reads_during_stall", rd_cnt, 2);
        fifo_empty = 1'b0;
        steps(6);
        chk("t2_reads", rd_cnt, 4);
        chk("t2_done_cyc", done_cyc, 10);
        chk("t2_err", done_err, 0);

        // 3. Timeout with FIFO empty throughout
        fifo_empty = 1'b1;
        new_rise();
        steps(20);
        chk("t3_reads", rd_cnt, 0);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_done_cyc", done_cyc, 17);
        chk("t3_err", done_err, 1);
        chk("t3_beat", done_beat, 0);
        @(negedge clk);
        chk("t3_err_cleared", int'(burst_err), 0);
        @(posedge clk);
        #1;
        fifo_empty = 1'b0;

        // 4. Drops: one in BURST (cycle 2), one in the DONE cycle (cycle 5)
        new_rise();
        step();                 // cycle 0: accepted rise
        rd_en_i = 1'b0; step(); // cycle 1
        rd_en_i = 1'b1; step(); // cycle 2: dropped
        rd_en_i = 1'b0; step(); // cycle 3
        step();                 // cycle 4
        rd_en_i = 1'b1;         // cycle 5 (DONE): dropped
        steps(5);
        chk("t4_reads", rd_cnt, 4);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_drop2", int'(drop_cnt), exp_drop2);

        // 4b. Three more drops during a stalled burst -> saturation
        new_rise();
        step();                 // cycle 0: accepted rise
        fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_en_i = 1'b0; step();
            rd_en_i = 1'b1; step();
        end
        rd_en_i    = 1'b0;
        step();
        fifo_empty = 1'b0;
        steps(6);
        chk("t4_sat_reads", rd_cnt, 4);
        chk("t4_sat_err", done_err, 0);
        chk("t4_drop_sat", int'(drop_cnt), exp_drop5);

        // 5. Held level yields one burst; low-then-high yields another
        new_rise();
        steps(40);
        chk("t5_held_done_cnt", done_cnt, 1);
        chk("t5_held_reads", rd_cnt, 4);
        new_rise();
        steps(8);
        chk("t5_second_done_cnt", done_cnt, 1);
        chk("t5_second_reads", rd_cnt, 4);

        // 6. Reset after two reads
        new_rise();
        steps(3);
        chk("t6_reads_before_rst", rd_cnt, 2);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_fifo_rd_in_rst", int'(fifo_rd), 0);
        @(posedge clk);
        #1;
        steps(2);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_reads_total", rd_cnt, 2);
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_fifo_rd", int'(fifo_rd), 0);
        chk("t6_beat", int'(beat_cnt), 0);
        chk("t6_done", int'(burst_done), 0);
        chk("t6_err", int'(burst_err), 0);
        chk("t6_drop", int'(drop_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net: the directed sequence is short, so this bound is never reached normally.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
